// File: rtl/cmos_i2c_sched_if.sv
// Handshake bundle between the SCCB scheduler (master) and the i2c_com style write engine (slave).
interface cmos_i2c_sched_if;
  localparam int unsigned DATA_W = 32;

  logic              eng_start;
  logic [DATA_W-1:0] eng_data;
  logic              eng_tr_end;
  logic              eng_nack;

  modport master (output eng_start, output eng_data, input eng_tr_end, input eng_nack);
  modport slave  (input eng_start, input eng_data, output eng_tr_end, output eng_nack);
endinterface

// File: rtl/cmos_i2c_sched.sv
// cmos_i2c_sched: shares one OV5640 SCCB write engine between the boot register table and a
// runtime host write port, inserts the settle delay after a software-reset write, counts NACKs.
// Optional feature macro: CMOS_SCHED_RETRY_EN (re-issue NACKed words up to MAX_RETRY times).
module cmos_i2c_sched #(
  parameter logic [7:0]  DEV_ADDR      = 8'h78,
  parameter int unsigned TABLE_LEN     = 253,
  parameter int unsigned RST_DELAY_CYC = 125000,
  parameter int unsigned GAP_CYC       = 4
`ifdef CMOS_SCHED_RETRY_EN
  , parameter int unsigned MAX_RETRY   = 3
`endif
) (
  input  logic             clk_25M,
  input  logic             camera_rstn,
  input  logic             initial_en,
  output logic [8:0]       tbl_index,
  input  logic [23:0]      tbl_data,
  output logic             cfg_done,
  input  logic             host_valid,
  input  logic [23:0]      host_data,
  output logic             host_ready,
  output logic             host_err,
  output logic [7:0]       err_cnt,
  cmos_i2c_sched_if.master eng
);

  localparam int unsigned IDX_W   = 9;
  localparam int unsigned WORD_W  = 24;
  localparam int unsigned CNT_MAX = (RST_DELAY_CYC > GAP_CYC) ? RST_DELAY_CYC : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_END, RELEASE, DELAY, GAP} state_t;
  typedef enum logic {SRC_TABLE, SRC_HOST} src_t;

  state_t             state, state_nx;
  src_t               src, src_nx;
  logic [WORD_W-1:0]  word, word_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               nack_q, nack_nx;
  logic               init_seen, init_seen_nx;
  logic [IDX_W-1:0]   tbl_index_nx;
  logic               cfg_done_nx, host_ready_nx, host_err_nx;
  logic [7:0]         err_cnt_nx;
  logic               eng_start_q, eng_start_nx;
  logic [31:0]        eng_data_q, eng_data_nx;
  logic               rst_word_c, final_nack_c, retry_c;

  assign eng.eng_start = eng_start_q;
  assign eng.eng_data  = eng_data_q;

  // Sensor software reset: register 0x3008 with bit 7 set needs the settle delay.
  assign rst_word_c = (eng_data_q[23:8] == 16'h3008) && eng_data_q[7];

`ifdef CMOS_SCHED_RETRY_EN
  localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_W-1:0] retry_cnt, retry_cnt_nx;

  // Per-word attempt counter; cleared whenever a new word is taken.
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) retry_cnt <= '0;
    else              retry_cnt <= retry_cnt_nx;
  end

  assign final_nack_c = nack_q && (retry_cnt == RTY_W'(MAX_RETRY));
  assign retry_c      = nack_q && !final_nack_c;
`else
  assign final_nack_c = nack_q;
  assign retry_c      = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk_25M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state       <= IDLE;
      src         <= SRC_TABLE;
      word        <= '0;
      cnt         <= '0;
      nack_q      <= 1'b0;
      init_seen   <= 1'b0;
      tbl_index   <= '0;
      cfg_done    <= 1'b0;
      host_ready  <= 1'b0;
      host_err    <= 1'b0;
      err_cnt     <= '0;
      eng_start_q <= 1'b0;
      eng_data_q  <= '0;
    end else begin
      state       <= state_nx;
      src         <= src_nx;
      word        <= word_nx;
      cnt         <= cnt_nx;
      nack_q      <= nack_nx;
      init_seen   <= init_seen_nx;
      tbl_index   <= tbl_index_nx;
      cfg_done    <= cfg_done_nx;
      host_ready  <= host_ready_nx;
      host_err    <= host_err_nx;
      err_cnt     <= err_cnt_nx;
      eng_start_q <= eng_start_nx;
      eng_data_q  <= eng_data_nx;
    end
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_nx     = state;
    src_nx       = src;
    word_nx      = word;
    cnt_nx       = cnt;
    nack_nx      = nack_q;
    init_seen_nx = init_seen | initial_en;
    tbl_index_nx = tbl_index;
    cfg_done_nx  = cfg_done;
    host_err_nx  = 1'b0;
    err_cnt_nx   = err_cnt;
    eng_start_nx = eng_start_q;
    eng_data_nx  = eng_data_q;
`ifdef CMOS_SCHED_RETRY_EN
    retry_cnt_nx = retry_cnt;
`endif

    case (state)
      IDLE: begin
        if (!cfg_done && (init_seen || initial_en)) begin
          if (TABLE_LEN == 0) begin
            cfg_done_nx = 1'b1;
          end else begin
            src_nx   = SRC_TABLE;
            state_nx = LOAD;
          end
`ifdef CMOS_SCHED_RETRY_EN
          retry_cnt_nx = '0;
`endif
        end else if (cfg_done && host_valid) begin
          word_nx  = host_data;
          src_nx   = SRC_HOST;
          state_nx = LOAD;
`ifdef CMOS_SCHED_RETRY_EN
          retry_cnt_nx = '0;
`endif
        end
      end
      LOAD: begin
        eng_data_nx = {DEV_ADDR, (src == SRC_HOST) ? word : tbl_data};
        state_nx    = ISSUE;
      end
      ISSUE: begin
        eng_start_nx = 1'b1;
        state_nx     = WAIT_END;
      end
      WAIT_END: begin
        if (eng.eng_tr_end) begin
          nack_nx      = eng.eng_nack;
          eng_start_nx = 1'b0;
          state_nx     = RELEASE;
        end
      end
      RELEASE: begin
        if (!eng.eng_tr_end) begin
          cnt_nx = '0;
          if (rst_word_c && !nack_q) begin
            state_nx = DELAY;
          end else begin
            state_nx = GAP;
            if (final_nack_c) begin
              err_cnt_nx  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
              host_err_nx = (src == SRC_HOST);
            end
          end
        end
      end
      DELAY: begin
        if (cnt == CNT_W'(RST_DELAY_CYC - 1)) begin
          cnt_nx   = '0;
          state_nx = GAP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          cnt_nx = '0;
          if (retry_c) begin
            state_nx = LOAD;
`ifdef CMOS_SCHED_RETRY_EN
            retry_cnt_nx = retry_cnt + RTY_W'(1);
`endif
          end else if (src == SRC_HOST) begin
            state_nx = IDLE;
          end else if (tbl_index == IDX_W'(TABLE_LEN - 1)) begin
            cfg_done_nx = 1'b1;
            state_nx    = IDLE;
          end else begin
            tbl_index_nx = tbl_index + IDX_W'(1);
            state_nx     = LOAD;
`ifdef CMOS_SCHED_RETRY_EN
            retry_cnt_nx = '0;
`endif
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    host_ready_nx = cfg_done_nx && (state_nx == IDLE);
  end

endmodule
